// File: rtl/clk_ratio_pkg.sv
// Shared types and default constants for the divided-clock ratio detector.
// No ports; imported by clk_ratio_detector and sync_edge_detect.
package clk_ratio_pkg;

  localparam int unsigned RATIO_W_DEF     = 8;
  localparam int unsigned MAX_RATIO_DEF   = 255;
  localparam int unsigned LOCK_CNT_DEF    = 4;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef logic [RATIO_W_DEF-1:0] ratio_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_EDGE,
    MEASURE,
    LOCKED
  } ratio_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level into the clock domain through SYNC_STAGES
// flops and emits a registered one-cycle pulse on each synchronized rising
// edge. The pulse appears SYNC_STAGES+1 cycles after the input rises.
// Ports:
//   clock      in   system clock
//   reset_n    in   asynchronous active-low reset
//   async_in   in   asynchronous input level
//   rise_pulse out  one-cycle pulse per rising edge of async_in
module sync_edge_detect
  import clk_ratio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clock,
  input  logic reset_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      last_q     <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in};
      last_q     <= sync_q[SYNC_STAGES-1];
      rise_pulse <= sync_q[SYNC_STAGES-1] & ~last_q;
    end
  end

endmodule

// File: rtl/clk_ratio_detector.sv
// Measures the period of a divided clock in system-clock cycles, reports it
// as an integer ratio, asserts lock after LOCK_CNT identical measurements,
// and flags timeouts and lock loss.
// Ports:
//   clock        in   system clock (rising edge)
//   reset_n      in   asynchronous active-low reset
//   enable       in   measurement enable
//   div_clk_in   in   divided clock under test (asynchronous)
//   clr_err      in   one-cycle pulse clearing err
//   ratio        out  last measured period in clock cycles
//   ratio_valid  out  one-cycle pulse when ratio updates
//   locked       out  ratio stable for LOCK_CNT measurements
//   timeout      out  no edge seen within MAX_RATIO cycles
//   err          out  sticky lock-lost / timeout flag
module clk_ratio_detector
  import clk_ratio_pkg::*;
#(
  parameter int unsigned RATIO_W     = RATIO_W_DEF,
  parameter int unsigned MAX_RATIO   = MAX_RATIO_DEF,
  parameter int unsigned LOCK_CNT    = LOCK_CNT_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               div_clk_in,
  input  logic               clr_err,
  output logic [RATIO_W-1:0] ratio,
  output logic               ratio_valid,
  output logic               locked,
  output logic               timeout,
  output logic               err
);

  localparam int unsigned        MATCH_W    = $clog2(LOCK_CNT + 1);
  localparam logic [RATIO_W-1:0] CNT_MAX    = RATIO_W'(MAX_RATIO);
  localparam logic [RATIO_W-1:0] CNT_LAST   = RATIO_W'(MAX_RATIO - 1);
  localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_CNT);

  ratio_state_e       state_q, state_d;
  logic [RATIO_W-1:0] cnt_q, cnt_d;
  logic [RATIO_W-1:0] prev_q, prev_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [RATIO_W-1:0] ratio_d;
  logic               valid_d, locked_d, timeout_d, set_err;
  logic               edge_pulse;
  logic [RATIO_W-1:0] period;
  logic               to_hit;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clock     (clock),
    .reset_n   (reset_n),
    .async_in  (div_clk_in),
    .rise_pulse(edge_pulse)
  );

  assign period = cnt_q + RATIO_W'(1);
  // Fires once: the period would pass MAX_RATIO if no edge arrives this cycle.
  // An edge in the same cycle takes priority.
  assign to_hit = ~edge_pulse & (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prev_d    = prev_q;
    match_d   = match_q;
    ratio_d   = ratio;
    valid_d   = 1'b0;
    locked_d  = locked;
    timeout_d = timeout;
    set_err   = 1'b0;

    if (edge_pulse) begin
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + RATIO_W'(1);
    end

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        prev_d    = '0;
        match_d   = '0;
        ratio_d   = '0;
        locked_d  = 1'b0;
        timeout_d = 1'b0;
        state_d   = WAIT_EDGE;
      end
      WAIT_EDGE: begin
        if (edge_pulse) begin
          state_d = MEASURE;
          match_d = '0;
          prev_d  = '0;
        end else if (to_hit) begin
          timeout_d = 1'b1;
          set_err   = 1'b1;
        end
      end
      MEASURE: begin
        if (edge_pulse) begin
          ratio_d = period;
          valid_d = 1'b1;
          if (period == prev_q) begin
            match_d = match_q + MATCH_W'(1);
          end else begin
            match_d = MATCH_W'(1);
            prev_d  = period;
          end
          if (match_d == MATCH_LOCK) begin
            state_d  = LOCKED;
            locked_d = 1'b1;
          end
        end else if (to_hit) begin
          state_d   = WAIT_EDGE;
          match_d   = '0;
          timeout_d = 1'b1;
          set_err   = 1'b1;
        end
      end
      LOCKED: begin
        if (edge_pulse) begin
          valid_d = 1'b1;
          if (period != ratio) begin
            ratio_d  = period;
            locked_d = 1'b0;
            set_err  = 1'b1;
            state_d  = MEASURE;
            match_d  = MATCH_W'(1);
            prev_d   = period;
          end
        end else if (to_hit) begin
          state_d   = WAIT_EDGE;
          match_d   = '0;
          locked_d  = 1'b0;
          timeout_d = 1'b1;
          set_err   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable overrides everything except the sticky error flag.
    if (!enable) begin
      state_d   = IDLE;
      cnt_d     = '0;
      prev_d    = '0;
      match_d   = '0;
      ratio_d   = '0;
      valid_d   = 1'b0;
      locked_d  = 1'b0;
      timeout_d = 1'b0;
      set_err   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prev_q      <= '0;
      match_q     <= '0;
      ratio       <= '0;
      ratio_valid <= 1'b0;
      locked      <= 1'b0;
      timeout     <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      match_q     <= match_d;
      ratio       <= ratio_d;
      ratio_valid <= valid_d;
      locked      <= locked_d;
      timeout     <= timeout_d;
      // A new error event beats a simultaneous clear.
      err         <= set_err | (err & ~clr_err);
    end
  end

endmodule
